// File: rtl/sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sub_bytes_pipe
//  Description : Pipelined AES byte-substitution engine. Every accepted beat
//                has the forward S-box (encrypt) or the inverse S-box
//                (decrypt) applied to each of its LANES bytes in parallel.
//                The mode bit travels with its beat, so forward and inverse
//                beats may be freely interleaved. Valid/ready on both sides.
//  Parameters  : LANES       - bytes substituted per beat (1..16)
//                PIPE_STAGES - register stages from input to output (1 or 2)
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-high reset
//                in_valid   - input beat present
//                in_ready   - engine accepts a beat this cycle
//                in_inv     - 0 = forward S-box, 1 = inverse S-box
//                in_data    - lane i = in_data[8*i+7:8*i]
//                out_valid  - result beat present
//                out_ready  - downstream accepts the result this cycle
//                out_data   - lane i = S(lane i) or S^-1(lane i)
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data
);

    localparam int         c_W        = 8 * LANES;
    localparam logic [7:0] c_POLY     = 8'h1b;  // x^8 + x^4 + x^3 + x + 1, low byte
    localparam logic [7:0] c_FWD_CONST = 8'h63;
    localparam logic [7:0] c_INV_CONST = 8'h05;

    // ------------------------------------------------------------------------
    // GF(2^8) arithmetic
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? c_POLY : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128.
    // Zero maps to zero without a special case, as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Forward S-box = affine(inv(x)); inverse S-box = inv(affine^-1(x)).
    // Both directions share one field inverter per lane: the inverse mode
    // applies its affine map before the inverter, the forward mode after.
    function automatic logic [7:0] sbox_any(input logic [7:0] x, input logic inv);
        logic [7:0] pre;
        logic [7:0] y;
        logic [7:0] fwd;
        pre = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ c_INV_CONST;
        y   = gf_inv(inv ? pre : x);
        fwd = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                ^ {y[3:0], y[7:4]} ^ c_FWD_CONST;
        return inv ? y : fwd;
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic             r_vld  [PIPE_STAGES];
    logic             r_inv  [PIPE_STAGES];
    logic [c_W-1:0]   r_data [PIPE_STAGES];

    logic             w_src_vld  [PIPE_STAGES];
    logic             w_src_inv  [PIPE_STAGES];
    logic [c_W-1:0]   w_src_data [PIPE_STAGES];

    logic [PIPE_STAGES:0] w_rdy;
    logic [c_W-1:0]       w_lut_in;
    logic [c_W-1:0]       w_lut_out;
    logic                 w_lut_inv;

    // A stage can load when it is empty or when its contents move on this
    // cycle; evaluated from the output end so a full pipe still streams.
    always_comb begin
        w_rdy              = '0;
        w_rdy[PIPE_STAGES] = out_ready;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            w_rdy[s] = !r_vld[s] || w_rdy[s+1];
        end
    end

    // ------------------------------------------------------------------------
    // Placement of the lookup within the pipe
    // ------------------------------------------------------------------------
    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            // Stage 0 captures the raw beat; lookup sits between stage 0 and 1.
            assign w_lut_in      = r_data[0];
            assign w_lut_inv     = r_inv[0];
            assign w_src_vld[0]  = in_valid;
            assign w_src_inv[0]  = in_inv;
            assign w_src_data[0] = in_data;
            assign w_src_vld[1]  = r_vld[0];
            assign w_src_inv[1]  = r_inv[0];
            assign w_src_data[1] = w_lut_out;
        end else begin : g_one_stage
            // Lookup directly on the input bus into the only stage.
            assign w_lut_in      = in_data;
            assign w_lut_inv     = in_inv;
            assign w_src_vld[0]  = in_valid;
            assign w_src_inv[0]  = in_inv;
            assign w_src_data[0] = w_lut_out;
        end
    endgenerate

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_lut_out[8*i +: 8] = sbox_any(w_lut_in[8*i +: 8], w_lut_inv);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage registers: load when ready, otherwise hold everything unchanged
    // ------------------------------------------------------------------------
    generate
        for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld[s]  <= 1'b0;
                    r_inv[s]  <= 1'b0;
                    r_data[s] <= '0;
                end else if (w_rdy[s]) begin
                    r_vld[s]  <= w_src_vld[s];
                    r_inv[s]  <= w_src_inv[s];
                    r_data[s] <= w_src_data[s];
                end
            end
        end
    endgenerate

    assign in_ready  = w_rdy[0];
    assign out_valid = r_vld[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_bytes_pipe
//  Description : Self-checking bench for sub_bytes_pipe. Three instances:
//                A (LANES=4, 2 stages), B (LANES=16, 1 stage),
//                C (LANES=1, 2 stages). Expected beats are queued per
//                instance at input acceptance and compared at output
//                transfer. The golden S-box is built from log/antilog tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_pipe;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic [2:0]   in_valid  = '0;
    logic [2:0]   in_inv    = '0;
    logic [2:0]   out_ready = 3'b111;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [127:0] in_data [3];
    logic [31:0]  a_out;
    logic [127:0] b_out;
    logic [7:0]   c_out;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]   sbox_ref  [256];
    logic [7:0]   isbox_ref [256];
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];

    always #5 clk = ~clk;

    sub_bytes_pipe #(.LANES(4), .PIPE_STAGES(2)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inv(in_inv[0]),
        .in_data(in_data[0][31:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(a_out)
    );
    sub_bytes_pipe #(.LANES(16), .PIPE_STAGES(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inv(in_inv[1]),
        .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(b_out)
    );
    sub_bytes_pipe #(.LANES(1), .PIPE_STAGES(2)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_inv(in_inv[2]),
        .in_data(in_data[2][7:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(c_out)
    );

    // ---------------------------------------------------------------- helpers
    function automatic int lanes_of(input int id);
        case (id)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] mask_of(input int id);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < lanes_of(id); i++) m[8*i +: 8] = 8'hff;
        return m;
    endfunction

    function automatic logic [127:0] get_out(input int id);
        case (id)
            0:       return {96'b0, a_out};
            1:       return b_out;
            default: return {120'b0, c_out};
        endcase
    endfunction

    function automatic logic [127:0] model(input int id, input logic inv, input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes_of(id); i++)
            r[8*i +: 8] = inv ? isbox_ref[d[8*i +: 8]] : sbox_ref[d[8*i +: 8]];
        return r;
    endfunction

    function automatic void push(input int id, input logic [127:0] v);
        case (id)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic logic [127:0] pop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // Golden tables from generator 3: inverse via log/antilog, then affine map.
    task automatic build_tables();
        logic [7:0] e [256];
        int         lg [256];
        logic [7:0] y, b, c;
        c    = 8'h63;
        e[0] = 8'h01;
        for (int i = 0; i < 255; i++) begin
            lg[e[i]] = i;
            e[i+1]   = e[i] ^ ({e[i][6:0], 1'b0} ^ (e[i][7] ? 8'h1b : 8'h00));
        end
        for (int x = 0; x < 256; x++) begin
            y = (x == 0) ? 8'h00 : e[(255 - lg[x]) % 255];
            for (int k = 0; k < 8; k++)
                b[k] = y[k] ^ y[(k+4)%8] ^ y[(k+5)%8] ^ y[(k+6)%8] ^ y[(k+7)%8] ^ c[k];
            sbox_ref[x]  = b;
            isbox_ref[b] = x[7:0];
        end
    endtask

    // ---------------------------------------------------------------- monitor
    // Sampled mid-cycle: values seen here decide the transfer at the next edge.
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) begin
            if (rst) begin
                case (id)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
            end else if (out_valid[id] && out_ready[id]) begin
                if (qsize(id) == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out[%0d]: got %h expected none", id, get_out(id));
                end else begin
                    chk($sformatf("out_data[%0d]", id), get_out(id), pop(id));
                end
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input int id, input logic inv, input logic [127:0] d,
                        input logic [127:0] exp, output int stalls);
        stalls       = 0;
        in_valid[id] = 1'b1;
        in_inv[id]   = inv;
        in_data[id]  = d;
        @(negedge clk);
        while (!in_ready[id] && stalls < 500) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready[id]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout[%0d]: got in_ready=0 expected 1", id);
        end else begin
            push(id, exp);
        end
        @(posedge clk);
        #1;
        in_valid[id] = 1'b0;
    endtask

    task automatic lat_check(input int id, input int exp_lat);
        int cyc;
        cyc = 1;
        @(negedge clk);
        while (!out_valid[id] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("latency[%0d]", id), 128'(cyc), 128'(exp_lat));
    endtask

    task automatic rand_run(input int id, input int nbeats);
        bit           done;
        int           st;
        logic [127:0] d;
        logic         inv;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < nbeats; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    d   = {$urandom, $urandom, $urandom, $urandom} & mask_of(id);
                    inv = 1'($urandom_range(0, 1));
                    send(id, inv, d, model(id, inv, d), st);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready[id] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[id] = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk($sformatf("drain[%0d]", id), 128'(qsize(id)), 128'(0));
    endtask

    // ---------------------------------------------------------------- stimulus
    typedef struct {
        logic        inv;
        logic [31:0] din;
        logic [31:0] dexp;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        vec_t         tbl [4];
        int           st;
        int           stall_sum;
        int           acc;
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] snap;

        tbl[0] = '{1'b0, 32'h53_01_00_52, 32'hED_7C_63_00};
        tbl[1] = '{1'b1, 32'h00_7C_63_ED, 32'h52_01_00_53};
        tbl[2] = '{1'b0, 32'hFF_10_01_00, 32'h16_CA_7C_63};
        tbl[3] = '{1'b1, 32'h16_CA_7C_63, 32'hFF_10_01_00};

        for (int id = 0; id < 3; id++) in_data[id] = '0;
        build_tables();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_data_a", 128'(a_out), 128'(0));
        chk("reset_out_data_b", b_out, 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(3'b111));
        @(posedge clk);
        #1;

        // Directed vectors with latency
        for (int i = 0; i < 4; i++) begin
            send(0, tbl[i].inv, {96'b0, tbl[i].din}, {96'b0, tbl[i].dexp}, st);
            lat_check(0, 2);
            @(posedge clk);
            #1;
        end
        send(1, 1'b0, '0, model(1, 1'b0, '0), st);
        lat_check(1, 1);
        @(posedge clk);
        #1;

        // Round trip of all 256 byte values
        for (int b = 0; b < 256; b += 4) begin
            d = {96'b0, 8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
            e = model(0, 1'b0, d);
            send(0, 1'b0, d, e, st);
            send(0, 1'b1, e, d, st);
        end
        repeat (4) begin @(posedge clk); #1; end

        // Interleaved modes back to back: no input stalls
        stall_sum = 0;
        for (int k = 0; k < 8; k++) begin
            d = {96'b0, $urandom};
            send(0, 1'(k), d, model(0, 1'(k), d), st);
            stall_sum += st;
        end
        chk("interleave_stalls", 128'(stall_sum), 128'(0));
        repeat (4) begin @(posedge clk); #1; end

        // Backpressure: 5 cycles of out_ready=0 while driving
        out_ready[0] = 1'b0;
        acc  = 0;
        snap = '0;
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            in_inv[0]   = 1'(acc);
            d           = {96'b0, {4{8'(8'h40 + acc)}}};
            in_data[0]  = d;
            @(negedge clk);
            if (in_ready[0]) begin
                push(0, model(0, 1'(acc), d));
                acc++;
            end
            if (k == 2) snap = {96'b0, a_out};
            if (k == 4) begin
                chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
                chk("bp_data_stable", {96'b0, a_out}, snap);
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 128'(acc), 128'(2));
        chk("bp_in_ready", 128'(in_ready[0]), 128'(0));
        out_ready[0] = 1'b1;
        while (acc < 5) begin
            d = {96'b0, {4{8'(8'h40 + acc)}}};
            send(0, 1'(acc), d, model(0, 1'(acc), d), st);
            acc++;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("bp_drain", 128'(qsize(0)), 128'(0));

        // Reset with two beats in flight
        out_ready[0] = 1'b0;
        send(0, 1'b0, {96'b0, 32'h11223344}, model(0, 1'b0, {96'b0, 32'h11223344}), st);
        send(0, 1'b1, {96'b0, 32'h55667788}, model(0, 1'b1, {96'b0, 32'h55667788}), st);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 128'(out_valid[0]), 128'(0));
        chk("rst_mid_out_data", 128'(a_out), 128'(0));
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        send(0, 1'b0, '0, {96'b0, 32'h63636363}, st);
        lat_check(0, 2);
        @(posedge clk);
        #1;

        // Random valid/ready on all three configurations
        fork
            rand_run(0, 60);
            rand_run(1, 60);
            rand_run(2, 60);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
